axis_slice_sequencer: RTL and testbench

- Accepts one wide AXI-stream word and emits it as an ordered sequence of narrow DOUT_WIDTH slices on a narrow AXI-stream output.
- Slices start at LOW_BIT and move upward. The number of slices per word is set at run time.
- Sits downstream of a wide producer, such as a 256-bit packer, and feeds a narrow consumer such as a 32-bit FIFO or a register-read path.
- Acts as the scheduler that walks the slice window across the word, so downstream logic never sees a static single-slice trim.

---
 rtl/axis_slice_sequencer_pkg.sv | 21 ++
 rtl/axis_slice_sequencer_if.sv | 25 ++
 rtl/axis_slice_sequencer.sv | 82 ++++++++
 tb/tb_axis_slice_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_slice_sequencer_pkg.sv
// Shared types and helpers for the slice sequencer.
// Holds the FSM encoding and the effective slice-count rule.
package axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Zero or an over-range request both mean "use every slice".
    function automatic int unsigned eff_slices(
        input int unsigned cfg,
        input int unsigned max_s
    );
        if (cfg == 0 || cfg > max_s) begin
            return max_s;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/axis_slice_sequencer_if.sv
// AXI-stream bundle, width set per instance.
// master drives data/valid/last, slave drives ready.
interface axis_slice_sequencer_if #(
    parameter int W = 32
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_slice_sequencer.sv
// Splits one wide AXI-stream word into narrow slices, lowest first.
// Slice count per word is sampled from cfg_slices at acceptance.
module axis_slice_sequencer #(
    parameter  int DIN_WIDTH  = 256,
    parameter  int DOUT_WIDTH = 32,
    parameter  int LOW_BIT    = 0,
    localparam int MAX_SLICES = (DIN_WIDTH - LOW_BIT) / DOUT_WIDTH,
    localparam int CNT_W      = $clog2(MAX_SLICES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CNT_W-1:0]       cfg_slices,
    axis_slice_sequencer_if.slave  axis_rx,
    axis_slice_sequencer_if.master axis_tx,
    output logic                   busy
);

    import axis_pkg::*;

    localparam int HW = DIN_WIDTH - LOW_BIT;

    state_t           state_q;
    state_t           state_d;
    logic [HW-1:0]    hold_q;
    logic [HW-1:0]    hold_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic             rdy_q;

    logic last;
    logic xfer;
    logic acc;

    assign last = (rem_q == CNT_W'(1));
    assign xfer = (state_q == EMIT) && axis_tx.tready;
    assign acc  = axis_rx.tvalid && axis_rx.tready;

    // Ready held low through reset; refills on the final slice transfer.
    assign axis_rx.tready =
        rdy_q && ((state_q == IDLE) || (xfer && last));

    assign axis_tx.tdata  = hold_q[DOUT_WIDTH-1:0];
    assign axis_tx.tvalid = (state_q == EMIT);
    assign axis_tx.tlast  = last;
    assign busy           = (state_q == EMIT);

    // Next state: shift out on transfer, a new accept overrides it.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rem_d   = rem_q;
        if (xfer) begin
            hold_d = hold_q >> DOUT_WIDTH;
            rem_d  = rem_q - CNT_W'(1);
            if (last) begin
                state_d = IDLE;
            end
        end
        if (acc) begin
            hold_d  = axis_rx.tdata[DIN_WIDTH-1:LOW_BIT];
            rem_d   = CNT_W'(eff_slices(32'(cfg_slices),
                                        MAX_SLICES));
            state_d = EMIT;
        end
    end

    // State, holding word, remaining count and ready enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_slice_sequencer.sv
// Randomised bench for axis_slice_sequencer with a word/index model.
// Two builds run side by side: LOW_BIT=0 and LOW_BIT=16.
module tb_axis_slice_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [255:0] s_data  = '0;
    logic         s_valid = 1'b0;
    logic         s_tready = 1'b1;
    logic [3:0]   s_cfg   = '0;
    logic [3:0]   cfg0;
    logic [2:0]   cfg1;
    logic         busy0;
    logic         busy1;

    assign cfg0 = s_cfg;
    assign cfg1 = s_cfg[2:0];

    axis_slice_sequencer_if #(.W(256)) rx0 ();
    axis_slice_sequencer_if #(.W(256)) rx1 ();
    axis_slice_sequencer_if #(.W(32))  tx0 ();
    axis_slice_sequencer_if #(.W(32))  tx1 ();

    assign rx0.tdata  = s_data;
    assign rx0.tvalid = s_valid;
    assign rx0.tlast  = 1'b0;
    assign rx1.tdata  = s_data;
    assign rx1.tvalid = s_valid;
    assign rx1.tlast  = 1'b0;
    assign tx0.tready = s_tready;
    assign tx1.tready = s_tready;

    axis_slice_sequencer #(
        .DIN_WIDTH (256),
        .DOUT_WIDTH(32),
        .LOW_BIT   (0)
    ) dut0 (
        .clk       (clk),
        .reset     (rst),
        .cfg_slices(cfg0),
        .axis_rx   (rx0),
        .axis_tx   (tx0),
        .busy      (busy0)
    );

    axis_slice_sequencer #(
        .DIN_WIDTH (256),
        .DOUT_WIDTH(32),
        .LOW_BIT   (16)
    ) dut1 (
        .clk       (clk),
        .reset     (rst),
        .cfg_slices(cfg1),
        .axis_rx   (rx1),
        .axis_tx   (tx1),
        .busy      (busy1)
    );

    logic [31:0] o_data [2];
    logic        o_valid[2];
    logic        o_last [2];
    logic        o_rdy  [2];
    logic        o_busy [2];

    assign o_data[0]  = tx0.tdata;
    assign o_data[1]  = tx1.tdata;
    assign o_valid[0] = tx0.tvalid;
    assign o_valid[1] = tx1.tvalid;
    assign o_last[0]  = tx0.tlast;
    assign o_last[1]  = tx1.tlast;
    assign o_rdy[0]   = rx0.tready;
    assign o_rdy[1]   = rx1.tready;
    assign o_busy[0]  = busy0;
    assign o_busy[1]  = busy1;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)",
                     nm, d, got, exp, $time);
        end
    endtask

    // Model: the held word, how many slices it yields, next index.
    logic [255:0] m_word[2] = '{default: '0};
    int           m_k[2]    = '{0, 0};
    int           m_n[2]    = '{0, 0};
    bit           m_rdy[2]  = '{0, 0};
    bit           m_acc[2]  = '{0, 0};
    int           lb[2]     = '{0, 16};
    int           mx[2]     = '{8, 7};

    function automatic int eff(input int c, input int m);
        return (c == 0 || c > m) ? m : c;
    endfunction

    function automatic bit m_act(input int d);
        return m_k[d] < m_n[d];
    endfunction

    function automatic bit m_last(input int d);
        return m_act(d) && (m_k[d] == m_n[d] - 1);
    endfunction

    function automatic logic [31:0] m_slice(input int d);
        logic [255:0] t;
        t = m_word[d] >> (lb[d] + 32 * m_k[d]);
        return t[31:0];
    endfunction

    function automatic bit m_ready(input int d);
        return m_rdy[d] && (!m_act(d) || (m_last(d) && s_tready));
    endfunction

    function automatic int cfg_of(input int d);
        return (d == 0) ? int'(s_cfg) : int'(s_cfg[2:0]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_k[d]   = 0;
                m_n[d]   = 0;
                m_rdy[d] = 0;
                m_acc[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit a;
                bit x;
                x = m_act(d) && s_tready;
                a = s_valid && m_ready(d);
                if (x) m_k[d]++;
                if (a) begin
                    m_word[d] = s_data;
                    m_k[d]    = 0;
                    m_n[d]    = eff(cfg_of(d), mx[d]);
                end
                m_acc[d] = a;
                m_rdy[d] = 1;
            end
        end
    end

    // Transfer log for the directed literal checks.
    logic [31:0] lg_d[2][16];
    bit          lg_l[2][16];
    int          lg_c[2][16];
    int          lg_n[2] = '{0, 0};

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("tvalid", d, 32'(o_valid[d]), 32'(m_act(d)));
            chk("busy", d, 32'(o_busy[d]), 32'(m_act(d)));
            chk("tlast", d, 32'(o_last[d]), 32'(m_last(d)));
            chk("rx_tready", d, 32'(o_rdy[d]), 32'(m_ready(d)));
            if (m_act(d)) begin
                chk("tdata", d, o_data[d], m_slice(d));
            end
            if (!rst && o_valid[d] && s_tready && lg_n[d] < 16) begin
                lg_d[d][lg_n[d]] = o_data[d];
                lg_l[d][lg_n[d]] = o_last[d];
                lg_c[d][lg_n[d]] = cyc;
                lg_n[d]++;
            end
        end
    end

    function automatic logic [255:0] lanes(input int base);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(base + k);
        return w;
    endfunction

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic send(input logic [255:0] w, input logic [3:0] c);
        lg_n[0] = 0;
        lg_n[1] = 0;
        s_data  = w;
        s_cfg   = c;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_cfg   = 4'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!m_act(0) && !m_act(1)) break;
        end
        vectors++;
        if (i >= 64) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, need idle",
                     nm, i);
        end
    endtask

    logic [255:0] wa;
    logic [255:0] wb;
    logic [255:0] w0;
    bit           pat[4] = '{1, 0, 0, 1};

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_tdata", 0, o_data[0], 32'h0);
        chk("rst_tvalid", 0, 32'(o_valid[0]), 32'h0);
        chk("rst_tlast", 0, 32'(o_last[0]), 32'h0);
        chk("rst_busy", 0, 32'(o_busy[0]), 32'h0);
        chk("rst_rx_tready", 0, 32'(o_rdy[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        w0 = lanes(0);
        send(w0, 4'd8);
        wait_idle("basic");
        chk("basic_n", 0, lg_n[0], 8);
        for (int k = 0; k < 8; k++) begin
            chk("basic_data", 0, lg_d[0][k], 32'(k));
            chk("basic_last", 0, 32'(lg_l[0][k]), 32'(k == 7));
        end
        chk("basic_span", 0, lg_c[0][7] - lg_c[0][0], 7);
        chk("lb16_n", 1, lg_n[1], 7);
        chk("lb16_s0", 1, lg_d[1][0], 32'h0001_0000);
        chk("lb16_s6", 1, lg_d[1][6], 32'h0007_0000);

        send(w0, 4'd3);
        wait_idle("cfg3");
        chk("cfg3_n", 0, lg_n[0], 3);
        chk("cfg3_s2", 0, lg_d[0][2], 32'h2);
        chk("cfg3_last", 0, 32'(lg_l[0][2]), 32'h1);
        chk("cfg3_n", 1, lg_n[1], 3);

        send(w0, 4'd0);
        wait_idle("cfg0");
        chk("cfg0_n", 0, lg_n[0], 8);
        chk("cfg0_n", 1, lg_n[1], 7);

        send(w0, 4'd15);
        wait_idle("cfg15");
        chk("cfg15_n", 0, lg_n[0], 8);

        wa = rnd_word();
        wb = rnd_word();
        lg_n[0] = 0;
        lg_n[1] = 0;
        s_data  = wa;
        s_cfg   = 4'd2;
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_data = wb;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (m_acc[0]) break;
        end
        @(negedge clk);
        s_valid = 1'b0;
        wait_idle("b2b");
        chk("b2b_n", 0, lg_n[0], 4);
        chk("b2b_a0", 0, lg_d[0][0], wa[31:0]);
        chk("b2b_a1", 0, lg_d[0][1], wa[63:32]);
        chk("b2b_b0", 0, lg_d[0][2], wb[31:0]);
        chk("b2b_b1", 0, lg_d[0][3], wb[63:32]);
        chk("b2b_span", 0, lg_c[0][3] - lg_c[0][0], 3);

        send(w0, 4'd8);
        for (int i = 0; i < 40; i++) begin
            s_tready = pat[i % 4];
            @(negedge clk);
        end
        s_tready = 1'b1;
        wait_idle("bp");
        chk("bp_n", 0, lg_n[0], 8);
        for (int k = 0; k < 8; k++) begin
            chk("bp_data", 0, lg_d[0][k], 32'(k));
        end

        for (int i = 0; i < 3000; i++) begin
            s_valid  = ($urandom % 4) != 0;
            s_data   = rnd_word();
            s_cfg    = 4'($urandom);
            s_tready = ($urandom % 4) != 0;
            @(negedge clk);
        end
        s_valid  = 1'b0;
        s_tready = 1'b1;
        wait_idle("random");

        send(w0, 4'd8);
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 0, 32'(o_valid[0]), 32'h0);
        chk("mid_rst_tvalid", 1, 32'(o_valid[1]), 32'h0);
        chk("mid_rst_busy", 0, 32'(o_busy[0]), 32'h0);
        chk("mid_rst_rx_tready", 0, 32'(o_rdy[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rel_rx_tready", 0, 32'(o_rdy[0]), 32'h1);
        @(negedge clk);
        send(lanes(32'h100), 4'd8);
        wait_idle("after_rst");
        chk("after_rst_n", 0, lg_n[0], 8);
        chk("after_rst_s0", 0, lg_d[0][0], 32'h100);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
